// File: rtl/exp_csr_frontend.sv
// Avalon-MM register front end for a downstream exponent engine.
// Latches operands, issues a start handshake, captures the result and cycle count, and raises an interrupt.
module exp_csr_frontend #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [23:0]       address,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic [DATA_W-1:0] eng_base,
  output logic [DATA_W-1:0] eng_exp,
  output logic              eng_start,
  input  logic              eng_ready,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic [DATA_W-1:0] conduit_export
);

  localparam logic [2:0] ADDR_BASE   = 3'd0;
  localparam logic [2:0] ADDR_EXP    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_CYCLES = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] base_reg;
  logic [DATA_W-1:0] exp_reg;
  logic [DATA_W-1:0] result_reg;
  logic [CNT_W-1:0]  cycles_reg;
  logic              done_reg;
  logic              err_reg;
  logic              irq_en_reg;

  logic              busy_c;
  logic              wr_base_c;
  logic              wr_exp_c;
  logic              wr_ctrl_c;
  logic              ctrl_start_c;
  logic              ctrl_clear_c;
  logic              start_ok_c;
  logic              in_wait_c;
  logic [CNT_W-1:0]  cycles_inc_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              unused_addr;

  assign unused_addr  = ^address[23:3];
  assign busy_c       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign in_wait_c    = (state == ST_WAIT);
  assign wr_base_c    = write && (address[2:0] == ADDR_BASE);
  assign wr_exp_c     = write && (address[2:0] == ADDR_EXP);
  assign wr_ctrl_c    = write && (address[2:0] == ADDR_CTRL);
  assign ctrl_start_c = wr_ctrl_c && writedata[0];
  assign ctrl_clear_c = wr_ctrl_c && writedata[1];
  assign start_ok_c   = ctrl_start_c && !busy_c;
  assign cycles_inc_c = (cycles_reg == {CNT_W{1'b1}}) ? cycles_reg : cycles_reg + CNT_W'(1);

  assign conduit_export = result_reg;

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_data_c = '0;
    case (address[2:0])
      ADDR_BASE:   rd_data_c = base_reg;
      ADDR_EXP:    rd_data_c = exp_reg;
      ADDR_STATUS: rd_data_c = DATA_W'({irq_en_reg, err_reg, done_reg, busy_c});
      ADDR_RESULT: rd_data_c = result_reg;
      ADDR_CYCLES: rd_data_c = DATA_W'(cycles_reg);
      default:     rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      base_reg   <= '0;
      exp_reg    <= '0;
      result_reg <= '0;
      cycles_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      irq_en_reg <= 1'b0;
      eng_base   <= '0;
      eng_exp    <= '0;
      eng_start  <= 1'b0;
      irq        <= 1'b0;
      readdata   <= '0;
    end else begin
      eng_start <= 1'b0;
      irq       <= done_reg && irq_en_reg;

      if (read) begin
        readdata <= rd_data_c;
      end

      if (wr_base_c && !busy_c) begin
        base_reg <= writedata;
      end
      if (wr_exp_c && !busy_c) begin
        exp_reg <= writedata;
      end
      if (wr_ctrl_c) begin
        irq_en_reg <= writedata[2];
      end

      // Clear first, then any error event in the same cycle wins
      if (ctrl_clear_c) begin
        err_reg <= 1'b0;
      end
      if ((busy_c && (wr_base_c || wr_exp_c || ctrl_start_c)) || (eng_done && !in_wait_c)) begin
        err_reg <= 1'b1;
      end

      // Clear or a new launch drops done; completion sets it and wins over clear
      if (ctrl_clear_c || start_ok_c) begin
        done_reg <= 1'b0;
      end
      if (eng_done && in_wait_c) begin
        done_reg <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok_c) begin
            state      <= ST_ISSUE;
            cycles_reg <= '0;
            eng_base   <= base_reg;
            eng_exp    <= exp_reg;
          end
        end
        ST_ISSUE: begin
          cycles_reg <= cycles_inc_c;
          if (eng_ready) begin
            eng_start <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cycles_reg <= cycles_inc_c;
          if (eng_done) begin
            result_reg <= eng_result;
            state      <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_csr_frontend.sv
// Self-checking bench for exp_csr_frontend: directed scenarios plus randomized operations
// against a transaction-level register model and a behavioural engine.
module tb_exp_csr_frontend;

  logic        clock;
  logic        reset;
  logic [23:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] eng_base;
  logic [31:0] eng_exp;
  logic        eng_start;
  logic        eng_ready;
  logic        eng_done;
  logic [31:0] eng_result;
  logic [31:0] conduit_export;

  exp_csr_frontend #(.DATA_W(32), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .write          (write),
    .read           (read),
    .writedata      (writedata),
    .readdata       (readdata),
    .irq            (irq),
    .eng_base       (eng_base),
    .eng_exp        (eng_exp),
    .eng_start      (eng_start),
    .eng_ready      (eng_ready),
    .eng_done       (eng_done),
    .eng_result     (eng_result),
    .conduit_export (conduit_export)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  // Transaction-level model of the register file
  logic [31:0] m_base, m_exp, m_ebase, m_eexp, m_result;
  int          m_cycles;
  bit          m_done, m_err, m_irq_en, m_busy;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'b0, m_irq_en, m_err, m_done, m_busy};
  endfunction

  function automatic logic [31:0] ipow(input logic [31:0] b, input int e);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  task automatic model_reset();
    m_base = '0; m_exp = '0; m_ebase = '0; m_eexp = '0; m_result = '0;
    m_cycles = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_busy = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address   = {21'($urandom), a};
    writedata = d;
    write     = 1'b1;
    step();
    write     = 1'b0;
    case (a)
      3'd0: if (m_busy) m_err = 1; else m_base = d;
      3'd1: if (m_busy) m_err = 1; else m_exp = d;
      3'd2: begin
        m_irq_en = d[2];
        if (d[1]) begin m_done = 0; m_err = 0; end
        if (d[0]) begin
          if (m_busy) m_err = 1;
          else begin
            m_busy = 1; m_done = 0; m_cycles = 0; m_ebase = m_base; m_eexp = m_exp;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] expected);
    address = {21'($urandom), a};
    read    = 1'b1;
    step();
    read    = 1'b0;
    chk(tag, readdata, expected);
  endtask

  task automatic check_regs(input string tag);
    rd({tag, "_base"},   3'd0, m_base);
    rd({tag, "_exp"},    3'd1, m_exp);
    rd({tag, "_status"}, 3'd3, m_status());
    rd({tag, "_result"}, 3'd4, m_result);
    rd({tag, "_cycles"}, 3'd5, 32'(m_cycles));
  endtask

  // One complete operation: stall cycles with eng_ready low, engine latency lat (>=2)
  task automatic do_op(input logic [31:0] b, input logic [31:0] e, input int stall,
                       input int lat, input bit poke, input bit clr_done);
    int remaining;
    wr(3'd0, b);
    wr(3'd1, e);
    eng_ready = (stall == 0);
    wr(3'd2, {29'b0, m_irq_en, 1'b0, 1'b1});
    remaining = stall;
    if (poke) begin
      wr(3'd0, 32'd7);
      wr(3'd1, 32'd9);
      wr(3'd2, {29'b0, m_irq_en, 1'b0, 1'b1});
      rd("busy_status", 3'd3, m_status());
      chk("busy_no_start", {31'b0, eng_start}, 32'd0);
      remaining = stall - 4;
    end
    for (int s = 0; s < remaining; s++) begin
      step();
      chk("stall_no_start", {31'b0, eng_start}, 32'd0);
    end
    eng_ready = 1'b1;
    step();
    chk("start_pulse", {31'b0, eng_start}, 32'd1);
    chk("eng_base", eng_base, m_ebase);
    chk("eng_exp", eng_exp, m_eexp);
    step();
    chk("start_single", {31'b0, eng_start}, 32'd0);
    repeat (lat - 2) step();
    eng_done   = 1'b1;
    eng_result = ipow(m_ebase, int'(m_eexp));
    if (clr_done) begin
      address   = 24'd2;
      writedata = {29'b0, m_irq_en, 1'b1, 1'b0};
      write     = 1'b1;
    end
    step();
    eng_done = 1'b0;
    write    = 1'b0;
    if (clr_done) begin m_done = 0; m_err = 0; end
    m_done   = 1;
    m_busy   = 0;
    m_result = eng_result;
    m_cycles = stall + 1 + lat;
    chk("conduit", conduit_export, m_result);
    chk("irq_lag", {31'b0, irq}, 32'd0);
    step();
    chk("irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
    check_regs("op");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
    eng_ready = 1'b1; eng_done = 1'b0; eng_result = '0;
    model_reset();
    step(); step();
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_eng_base", eng_base, 32'd0);
    chk("rst_conduit", conduit_export, 32'd0);
    chk("rst_ctl", {29'b0, irq, eng_start, 1'b0}, 32'd0);
    reset = 1'b0;
    step();
    check_regs("rst");
    rd("unmapped6", 3'd6, 32'd0);
    step();
    chk("readdata_hold", readdata, 32'd0);

    // Basic operation 3^4
    do_op(32'd3, 32'd4, 0, 10, 0, 0);
    chk("basic_result", conduit_export, 32'd81);
    // Engine stall of five cycles
    do_op(32'd3, 32'd4, 5, 10, 0, 0);
    // Writes and start while busy are rejected and flagged
    do_op(32'd3, 32'd4, 6, 10, 1, 0);
    chk("busy_base_kept", eng_base, 32'd3);
    // Interrupt enable, clear, and clear coincident with completion
    wr(3'd2, 32'd4);
    do_op(32'd2, 32'd5, 1, 4, 0, 0);
    wr(3'd2, 32'd6);
    step();
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    do_op(32'd5, 32'd3, 0, 3, 0, 1);
    // Engine done while idle sets err
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    m_err = 1;
    rd("stray_done", 3'd3, m_status());
    wr(3'd2, 32'd2);
    rd("err_cleared", 3'd3, m_status());

    // Randomized operations interleaved with ignored writes and unmapped reads
    for (int i = 0; i < 16; i++) begin
      wr(3'd2, {29'b0, 1'($urandom), 2'b00});
      wr(3'($urandom_range(3, 7)), $urandom);
      rd("rand_unmapped", 3'($urandom_range(6, 7)), 32'd0);
      do_op($urandom, 32'($urandom_range(0, 12)), $urandom_range(0, 4),
            $urandom_range(2, 15), 0, 1'($urandom_range(0, 3) == 0));
    end

    // Engine that never completes: counter saturates
    wr(3'd0, 32'd11);
    wr(3'd1, 32'd2);
    eng_ready = 1'b1;
    wr(3'd2, 32'd1);
    step();
    chk("sat_start", {31'b0, eng_start}, 32'd1);
    repeat (65546) step();
    m_cycles = 32'hFFFF;
    rd("sat_cycles", 3'd5, 32'(m_cycles));
    rd("sat_status", 3'd3, m_status());

    // Reset during WAIT abandons operation; later stray done flags err
    #2 reset = 1'b1;
    #1;
    chk("async_rst_readdata", readdata, 32'd0);
    chk("async_rst_conduit", conduit_export, 32'd0);
    chk("async_rst_eng", eng_base | eng_exp | {30'b0, irq, eng_start}, 32'd0);
    step();
    reset = 1'b0;
    model_reset();
    step();
    eng_result = 32'hDEAD_BEEF;
    eng_done   = 1'b1;
    step();
    eng_done   = 1'b0;
    m_err      = 1;
    check_regs("post_rst");
    chk("post_rst_conduit", conduit_export, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
